// File: rtl/demod_meas_ctrl_pkg.sv
// Shared definitions for the demodulator measurement sequencer.
package demod_meas_ctrl_pkg;

    // Sequencer state encoding, 3 bits wide; also exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_ARM     = 3'd2,
        ST_WINDOW  = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_CAPTURE = 3'd5
    } state_t;

    localparam int DEF_OUT_W     = 14;
    localparam int DEF_PDEV_W    = 42;
    localparam int DEF_CNT_W     = 24;
    localparam int DEF_DRAIN_CYC = 4;

endpackage

// File: rtl/demod_meas_ctrl_if.sv
// Control/data bundle between the UI side (master) and the measurement
// sequencer (slave).
//
// Handshake: start and abort are single-cycle requests sampled on every
// rising clock edge with no back-pressure. start is honoured only while busy
// is low, and abort wins over start. result_valid is a single-cycle pulse
// that is asserted in the same cycle the result registers take new values.
// The consumer must take the results in that cycle, or later, because the
// result registers hold until the next capture.
interface demod_meas_ctrl_if #(
    parameter int OUT_W  = 14,
    parameter int PDEV_W = 42,
    parameter int CNT_W  = 24
);
    logic                     start;
    logic                     abort;
    logic                     cfg_continuous;
    logic [CNT_W-1:0]         cfg_settle;
    logic [CNT_W-1:0]         cfg_window;
    logic signed [OUT_W-1:0]  am_in;
    logic signed [PDEV_W-1:0] phase_max;
    logic signed [PDEV_W-1:0] phase_min;
    logic                     meas_trigger;
    logic                     busy;
    logic                     result_valid;
    logic signed [OUT_W-1:0]  am_max;
    logic signed [OUT_W-1:0]  am_min;
    logic signed [OUT_W:0]    am_span;
    logic signed [PDEV_W:0]   phase_span;
    logic [2:0]               state_dbg;

    modport master (
        output start, abort, cfg_continuous, cfg_settle, cfg_window,
               am_in, phase_max, phase_min,
        input  meas_trigger, busy, result_valid, am_max, am_min,
               am_span, phase_span, state_dbg
    );

    modport slave (
        input  start, abort, cfg_continuous, cfg_settle, cfg_window,
               am_in, phase_max, phase_min,
        output meas_trigger, busy, result_valid, am_max, am_min,
               am_span, phase_span, state_dbg
    );
endinterface

// File: rtl/demod_meas_ctrl_extremum_track.sv
// Signed running maximum/minimum tracker. A load restarts both extremes from
// the current sample, and an enable folds a new sample into the extremes.
module meas_extremum_track #(
    parameter int W = 14
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] max_val,
    output logic signed [W-1:0] min_val
);

    // Load takes priority. Otherwise, the extremes follow din with a signed compare.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            min_val <= '0;
        end else if (load) begin
            max_val <= din;
            min_val <= din;
        end else if (en) begin
            if (din > max_val) max_val <= din;
            if (din < min_val) min_val <= din;
        end
    end

endmodule

// File: rtl/demod_meas_ctrl.sv
// Measurement window sequencer for the I/Q demodulation datapath. After start,
// it waits a settle time. It then fires meas_trigger, tracks the AM envelope
// extremes over the window, and waits for the phase pipeline to drain. Finally
// it captures phase and AM extremes together with their spans.
module demod_meas_ctrl
    import demod_meas_ctrl_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int PDEV_W    = DEF_PDEV_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic             clk_in,
    input  logic             rst,
    demod_meas_ctrl_if.slave bus
);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        shadow_settle;
    logic [CNT_W-1:0]        shadow_window;
    logic [CNT_W-1:0]        win_len;
    logic signed [OUT_W-1:0] trk_max;
    logic signed [OUT_W-1:0] trk_min;
    logic                    trk_load;
    logic                    trk_en;

    // A zero window is treated as a single-sample window.
    assign win_len = (shadow_window == '0) ? CNT_W'(1) : shadow_window;

    // The ARM sample seeds the tracker. WINDOW then folds in the next
    // win_len-1 samples. The final WINDOW cycle is a guard cycle in which the
    // tracker is already stable.
    assign trk_load = (state == ST_ARM);
    assign trk_en   = (state == ST_WINDOW) && (cnt != CNT_W'(1));

    assign bus.state_dbg = state;

    meas_extremum_track #(.W(OUT_W)) u_am_track (
        .clk_in  (clk_in),
        .rst     (rst),
        .load    (trk_load),
        .en      (trk_en),
        .din     (bus.am_in),
        .max_val (trk_max),
        .min_val (trk_min)
    );

    // Sequencer FSM. Counters load their terminal value and count down to 1,
    // and all outputs are registered.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            shadow_settle    <= '0;
            shadow_window    <= '0;
            bus.meas_trigger <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.am_max       <= '0;
            bus.am_min       <= '0;
            bus.am_span      <= '0;
            bus.phase_span   <= '0;
        end else begin
            bus.meas_trigger <= 1'b0;
            bus.result_valid <= 1'b0;
            if (bus.abort) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            shadow_settle <= bus.cfg_settle;
                            shadow_window <= bus.cfg_window;
                            bus.busy      <= 1'b1;
                            if (bus.cfg_settle == '0) begin
                                state            <= ST_ARM;
                                bus.meas_trigger <= 1'b1;
                            end else begin
                                state <= ST_SETTLE;
                                cnt   <= bus.cfg_settle;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt == CNT_W'(1)) begin
                            state            <= ST_ARM;
                            bus.meas_trigger <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_ARM: begin
                        state <= ST_WINDOW;
                        cnt   <= win_len;
                    end
                    ST_WINDOW: begin
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_DRAIN;
                            cnt   <= CNT_W'(DRAIN_CYC);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (cnt == CNT_W'(1)) state <= ST_CAPTURE;
                        else                  cnt   <= cnt - CNT_W'(1);
                    end
                    ST_CAPTURE: begin
                        bus.am_max       <= trk_max;
                        bus.am_min       <= trk_min;
                        bus.am_span      <= {trk_max[OUT_W-1], trk_max}
                                          - {trk_min[OUT_W-1], trk_min};
                        bus.phase_span   <= {bus.phase_max[PDEV_W-1], bus.phase_max}
                                          - {bus.phase_min[PDEV_W-1], bus.phase_min};
                        bus.result_valid <= 1'b1;
                        if (!bus.cfg_continuous) begin
                            state    <= ST_IDLE;
                            bus.busy <= 1'b0;
                        end else if (shadow_settle == '0) begin
                            state            <= ST_ARM;
                            bus.meas_trigger <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                            cnt   <= shadow_settle;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demod_meas_ctrl.sv
// Self-checking bench for demod_meas_ctrl. Each run is modelled as a timeline.
// The triggers, result pulses and busy interval follow from settle, window and
// drain. The expected extremes and spans are computed from the samples that
// fall inside each window.
module tb_demod_meas_ctrl;
    import demod_meas_ctrl_pkg::*;

    localparam int OUT_W     = 14;
    localparam int PDEV_W    = 42;
    localparam int CNT_W     = 24;
    localparam int DRAIN_CYC = 4;
    localparam longint PH_TOP = 64'sd2199023255551;   //  2^41-1
    localparam longint PH_BOT = -64'sd2199023255552;  // -2^41

    // ---------------- clock / reset ----------------
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_in = ~clk_in;

    demod_meas_ctrl_if #(.OUT_W(OUT_W), .PDEV_W(PDEV_W), .CNT_W(CNT_W)) bus ();

    demod_meas_ctrl #(
        .OUT_W(OUT_W), .PDEV_W(PDEV_W), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    int     errors = 0;
    int     checks = 0;
    int     exp_am_max = 0;
    int     exp_am_min = 0;
    int     exp_am_span = 0;
    longint exp_ph_span = 0;
    int     samp_q[$];
    longint cap_pmax = 0;
    longint cap_pmin = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, ".am_max"},     64'(bus.am_max),     64'(exp_am_max));
        chk({tag, ".am_min"},     64'(bus.am_min),     64'(exp_am_min));
        chk({tag, ".am_span"},    64'(bus.am_span),    64'(exp_am_span));
        chk({tag, ".phase_span"}, 64'(bus.phase_span), 64'(exp_ph_span));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic longint sx42(input longint v);
        return (v <<< 22) >>> 22;
    endfunction

    function automatic longint rand_ph();
        longint v;
        v = longint'({$urandom, $urandom});
        return sx42(v);
    endfunction

    // ---------------- driver + timeline model ----------------
    // Cycle 0 is the cycle in which start is presented. Triggers fall at
    // 1+s+i*(lat+s) and results at trigger+lat, where lat = window+DRAIN_CYC+2.
    // cfg_continuous is cleared at the last trigger, so n results are produced.
    // abort_at >= 0 injects an abort in that cycle. Nothing that would happen
    // after it is expected.
    task automatic run_meas(input int s, input int w, input int n,
                            input int am_mode, input int ph_mode, input int abort_at);
        int     we, lat, per, last_rv, end_cyc, in_win, a, mx, mn;
        int     t_i[4];
        int     rv_i[4];
        logic   alive, exp_trig, exp_rv, exp_busy, is_cap;
        longint pmx, pmn;
        we  = (w == 0) ? 1 : w;
        lat = we + DRAIN_CYC + 2;
        per = lat + s;
        for (int i = 0; i < 4; i++) begin
            t_i[i]  = 1 + s + i * per;
            rv_i[i] = t_i[i] + lat;
        end
        last_rv = rv_i[n-1];
        end_cyc = (abort_at >= 0) ? abort_at + 12 : last_rv + 3;
        samp_q.delete();
        for (int cyc = 0; cyc <= end_cyc; cyc++) begin
            alive    = (abort_at < 0) || (cyc <= abort_at);
            exp_trig = 1'b0;
            exp_rv   = 1'b0;
            is_cap   = 1'b0;
            in_win   = -1;
            for (int i = 0; i < n; i++) begin
                if (cyc == t_i[i]) exp_trig = 1'b1;
                if (cyc == rv_i[i]) exp_rv = 1'b1;
                if (cyc == rv_i[i] - 1) is_cap = 1'b1;
                if (cyc >= t_i[i] && cyc < t_i[i] + we) in_win = cyc - t_i[i];
            end
            exp_trig = exp_trig && alive;
            exp_rv   = exp_rv && alive;
            exp_busy = alive && (cyc >= 1) && (cyc < last_rv);

            // drive this cycle's inputs
            bus.start = (cyc == 0) || (cyc == 3 && exp_busy);
            bus.abort = (cyc == abort_at);
            if (cyc == 0) begin
                bus.cfg_settle     = CNT_W'(s);
                bus.cfg_window     = CNT_W'(w);
                bus.cfg_continuous = (n > 1);
            end else if (cyc == 1) begin
                bus.cfg_settle = CNT_W'($urandom_range(50));
                bus.cfg_window = CNT_W'($urandom_range(50));
            end
            if (n > 1 && cyc == t_i[n-1]) bus.cfg_continuous = 1'b0;
            a = int'($urandom_range(16383)) - 8192;
            if (in_win >= 0) begin
                if (am_mode == 0) a = -50 + in_win;
                if (am_mode == 2 && in_win == 0) a = 8191;
                if (am_mode == 2 && in_win == 1) a = -8192;
            end
            bus.am_in = a[OUT_W-1:0];
            case (ph_mode)
                1:       begin pmx = 1000;   pmn = -3000;  end
                2:       begin pmx = PH_TOP; pmn = PH_BOT; end
                default: begin pmx = rand_ph(); pmn = rand_ph(); end
            endcase
            bus.phase_max = pmx[PDEV_W-1:0];
            bus.phase_min = pmn[PDEV_W-1:0];

            // compare
            chk("meas_trigger", 64'(bus.meas_trigger), 64'(exp_trig));
            chk("result_valid", 64'(bus.result_valid), 64'(exp_rv));
            chk("busy",         64'(bus.busy),         64'(exp_busy));
            if (exp_rv) begin
                mx = samp_q[0];
                mn = samp_q[0];
                foreach (samp_q[k]) begin
                    if (samp_q[k] > mx) mx = samp_q[k];
                    if (samp_q[k] < mn) mn = samp_q[k];
                end
                exp_am_max  = mx;
                exp_am_min  = mn;
                exp_am_span = mx - mn;
                exp_ph_span = cap_pmax - cap_pmin;
                samp_q.delete();
            end
            chk_results("hold");
            if (in_win >= 0 && alive) samp_q.push_back(a);
            if (is_cap) begin
                cap_pmax = pmx;
                cap_pmin = pmn;
            end
            tick();
        end
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.cfg_continuous = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 0; bus.abort = 0; bus.cfg_continuous = 0;
        bus.cfg_settle = '0; bus.cfg_window = '0;
        bus.am_in = '0; bus.phase_max = '0; bus.phase_min = '0;
        repeat (3) tick();
        chk("rst.busy",    64'(bus.busy),         64'(0));
        chk("rst.trigger", 64'(bus.meas_trigger), 64'(0));
        chk("rst.rv",      64'(bus.result_valid), 64'(0));
        chk("rst.state",   64'(bus.state_dbg),    64'(ST_IDLE));
        chk_results("rst");
        rst = 1'b0;
        tick();

        // ramp window, settle 10 -> trigger at cycle 11, 49/-50/99
        run_meas(10, 100, 1, 0, 0, -1);
        chk("ramp.am_span", 64'(bus.am_span), 64'(99));
        // held phase values -> span 4000
        run_meas(3, 7, 1, 1, 1, -1);
        chk("const.phase_span", 64'(bus.phase_span), 64'(4000));
        // full-scale phase and AM
        run_meas(0, 4, 1, 2, 2, -1);
        chk("fs.phase_span", 64'(bus.phase_span), 64'(PH_TOP - PH_BOT));
        chk("fs.am_span",    64'(bus.am_span),    64'(16383));
        // continuous re-arm, without and with settle
        run_meas(0, 5, 3, 1, 0, -1);
        run_meas(2, 3, 2, 1, 0, -1);
        // abort in the middle of the window
        run_meas(5, 100, 1, 1, 0, 26);
        // start and abort together
        bus.cfg_settle = '0; bus.cfg_window = CNT_W'(3);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("sa.busy",    64'(bus.busy),         64'(0));
        chk("sa.trigger", 64'(bus.meas_trigger), 64'(0));
        chk("sa.state",   64'(bus.state_dbg),    64'(ST_IDLE));
        tick();
        // window 0 behaves as window 1
        run_meas(0, 0, 1, 1, 0, -1);
        run_meas(4, 0, 2, 1, 0, -1);
        // randomized configurations
        for (int k = 0; k < 4; k++)
            run_meas($urandom_range(6), $urandom_range(12), $urandom_range(1, 2), 1, 0, -1);

        // reset while in DRAIN: window 3 -> DRAIN covers cycles 5..8
        bus.cfg_settle = '0; bus.cfg_window = CNT_W'(3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("drain.state", 64'(bus.state_dbg), 64'(ST_DRAIN));
        rst = 1'b1;
        #1;
        exp_am_max = 0; exp_am_min = 0; exp_am_span = 0; exp_ph_span = 0;
        chk("mrst.state", 64'(bus.state_dbg),    64'(ST_IDLE));
        chk("mrst.busy",  64'(bus.busy),         64'(0));
        chk("mrst.rv",    64'(bus.result_valid), 64'(0));
        chk_results("mrst");
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk_results("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
